// File: rtl/hit_judge.sv
`default_nettype none
// ============================================================================
// Module      : hit_judge
// Description : Scoring engine for the whack-a-mole game. Judges each lit
//               window as a hit or a miss, keeps point / miss / round
//               counters for the HEX displays, and raises game_over on the
//               round limit or, in deathmatch mode, on the first miss.
//
// Optional feature macro:
//   WAM_WRONG_KEY_PENALTY_EN - when defined, a non-matching key press in an
//                              open window counts as a miss and closes it.
//                              When undefined, wrong keys are ignored.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high; clears all state
//   start         game enable level
//   light_valid   pulse: new light lit at light_pos
//   light_pos     lit LED position (sampled with light_valid)
//   light_expire  pulse: current light's on-time ended
//   key_valid     pulse: debounced key press
//   key           key code (sampled with key_valid)
//   max_hits      rounds per game, 0 = unlimited
//   deathmatch    1 = first miss ends the game
//   points        hits this game (saturating)
//   misses        misses this game (saturating)
//   rounds        judged windows this game (saturating)
//   hit / miss    one-cycle judgment pulses
//   armed         high while a light window is open
//   game_over     high while the game is over
//
// Revision    : 1.0 - initial release
// ============================================================================
module hit_judge #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             light_valid,
    input  logic [3:0]       light_pos,
    input  logic             light_expire,
    input  logic             key_valid,
    input  logic [3:0]       key,
    input  logic [CNT_W-1:0] max_hits,
    input  logic             deathmatch,
    output logic [CNT_W-1:0] points,
    output logic [CNT_W-1:0] misses,
    output logic [CNT_W-1:0] rounds,
    output logic             hit,
    output logic             miss,
    output logic             armed,
    output logic             game_over
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ARMED = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_target;
    logic [3:0]       w_target_next;
    logic [CNT_W-1:0] r_points;
    logic [CNT_W-1:0] r_misses;
    logic [CNT_W-1:0] r_rounds;
    logic             r_hit;
    logic             r_miss;

    logic             w_judge_hit;
    logic             w_judge_miss;
    logic             w_retarget;
    logic             w_clear;
    logic [CNT_W-1:0] w_rounds_inc;
    logic             w_game_end;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_CNT_MAX) ? v : (v + c_CNT_ONE);
    endfunction

    assign w_rounds_inc = sat_inc(r_rounds);

    // -------------------------------------------------------------------------
    // Next-state / judgment logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        w_judge_hit   = 1'b0;
        w_judge_miss  = 1'b0;
        w_retarget    = 1'b0;
        w_clear       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (!start) begin
                    w_state_next = S_IDLE;
                end else if (light_valid) begin
                    w_target_next = light_pos;
                    w_state_next  = S_ARMED;
                end
            end

            S_ARMED: begin
                // Dropping start abandons the window without judging it.
                if (!start) begin
                    w_state_next = S_IDLE;
                end else if (key_valid && (key == r_target)) begin
                    // A matching key beats a simultaneous expiry.
                    w_judge_hit = 1'b1;
`ifdef WAM_WRONG_KEY_PENALTY_EN
                end else if (key_valid) begin
                    w_judge_miss = 1'b1;
`endif
                end else if (light_expire) begin
                    w_judge_miss = 1'b1;
                end else if (light_valid) begin
                    // New light before expiry: old window is a miss, the
                    // new one opens immediately.
                    w_judge_miss  = 1'b1;
                    w_retarget    = 1'b1;
                    w_target_next = light_pos;
                end
            end

            S_OVER: begin
                if (!start) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_judge_hit || w_judge_miss) begin
            if (w_game_end) begin
                w_state_next = S_OVER;
            end else if (w_retarget) begin
                w_state_next = S_ARMED;
            end else begin
                w_state_next = S_WAIT;
            end
        end
    end

    // Game ends on the round limit (checked against the post-update count)
    // or on any miss in deathmatch.
    assign w_game_end = ((max_hits != '0) && (w_rounds_inc == max_hits)) ||
                        (deathmatch && w_judge_miss);

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_target <= 4'd0;
            r_points <= '0;
            r_misses <= '0;
            r_rounds <= '0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_target <= w_target_next;
            r_hit    <= w_judge_hit;
            r_miss   <= w_judge_miss;
            if (w_clear) begin
                r_points <= '0;
                r_misses <= '0;
                r_rounds <= '0;
            end else begin
                if (w_judge_hit) begin
                    r_points <= sat_inc(r_points);
                end
                if (w_judge_miss) begin
                    r_misses <= sat_inc(r_misses);
                end
                if (w_judge_hit || w_judge_miss) begin
                    r_rounds <= w_rounds_inc;
                end
            end
        end
    end

    assign points    = r_points;
    assign misses    = r_misses;
    assign rounds    = r_rounds;
    assign hit       = r_hit;
    assign miss      = r_miss;
    assign armed     = (r_state == S_ARMED);
    assign game_over = (r_state == S_OVER);

endmodule
`default_nettype wire
